// File: rtl/clkdiv_rst_seq.sv
// rtl/clkdiv_rst_seq.sv - reset sequencer driving the /2 CLKDIV wrapper resetn and the divided-domain reset
// Optional feature: define CLKDIV_SEQ_SOFTRST_EN to add the soft_rst input.
module clkdiv_rst_seq #(
  parameter int LOCK_SYNC_STAGES = 2,
  parameter int LOCK_STABLE_CYC  = 256,
  parameter int DIV_RST_HOLD     = 16,
  parameter int POST_REL_CYC     = 64,
  parameter int CNT_W            = 16
) (
  input  logic       hclkin,
  input  logic       rst,
  input  logic       pll_lock,
`ifdef CLKDIV_SEQ_SOFTRST_EN
  input  logic       soft_rst,
`endif
  output logic       clkdiv_resetn,
  output logic       div_rst,
  output logic       ready,
  output logic [7:0] relock_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STABLE = 3'd1,
    HOLD   = 3'd2,
    SETTLE = 3'd3,
    RUN    = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(DIV_RST_HOLD - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(POST_REL_CYC - 1);

  logic [LOCK_SYNC_STAGES-1:0] sync_q;
  logic                        lock_s;
  logic                        soft_req;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_clr;
  logic             clkdiv_resetn_q, clkdiv_resetn_d;
  logic             div_rst_q, div_rst_d;
  logic             ready_q, ready_d;
  logic [7:0]       relock_q, relock_d;

  assign lock_s = sync_q[LOCK_SYNC_STAGES-1];

`ifdef CLKDIV_SEQ_SOFTRST_EN
  assign soft_req = soft_rst;
`else
  assign soft_req = 1'b0;
`endif

  always_ff @(posedge hclkin or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[LOCK_SYNC_STAGES-2:0], pll_lock};
    end
  end

  // Lock loss is checked first in every active state so it always wins over soft_req.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (lock_s) state_d = STABLE;
      end
      STABLE: begin
        if (!lock_s)                   state_d = IDLE;
        else if (cnt_q == STABLE_LAST) state_d = HOLD;
      end
      HOLD: begin
        if (!lock_s)                 state_d = IDLE;
        else if (soft_req)           cnt_clr = 1'b1;
        else if (cnt_q == HOLD_LAST) state_d = SETTLE;
      end
      SETTLE: begin
        if (!lock_s)                   state_d = IDLE;
        else if (soft_req)             state_d = HOLD;
        else if (cnt_q == SETTLE_LAST) state_d = RUN;
      end
      RUN: begin
        if (!lock_s)       state_d = IDLE;
        else if (soft_req) state_d = HOLD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_d != state_q || cnt_clr || state_d == IDLE || state_d == RUN) begin
      cnt_d = '0;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    clkdiv_resetn_d = (state_d == SETTLE) || (state_d == RUN);
    div_rst_d       = (state_d != RUN);
    ready_d         = (state_d == RUN);
  end

  always_comb begin
    relock_d = relock_q;
    if (state_q == RUN && state_d == IDLE && relock_q != 8'hFF) begin
      relock_d = relock_q + 8'd1;
    end
  end

  always_ff @(posedge hclkin or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      clkdiv_resetn_q <= 1'b0;
      div_rst_q       <= 1'b1;
      ready_q         <= 1'b0;
      relock_q        <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      clkdiv_resetn_q <= clkdiv_resetn_d;
      div_rst_q       <= div_rst_d;
      ready_q         <= ready_d;
      relock_q        <= relock_d;
    end
  end

  assign clkdiv_resetn = clkdiv_resetn_q;
  assign div_rst       = div_rst_q;
  assign ready         = ready_q;
  assign relock_cnt    = relock_q;

endmodule

// File: tb/tb_clkdiv_rst_seq.sv
// tb/tb_clkdiv_rst_seq.sv - directed self-checking bench for clkdiv_rst_seq
// A second, short-parameter instance makes the 300-relock saturation run cheap.
module tb_clkdiv_rst_seq;

  logic       hclkin = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_lock_s = 1'b0;
  logic       soft_rst = 1'b0;
  logic       soft_rst_s = 1'b0;
  logic       clkdiv_resetn, div_rst, ready;
  logic [7:0] relock_cnt;
  logic       clkdiv_resetn_s, div_rst_s, ready_s;
  logic [7:0] relock_cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 hclkin = ~hclkin;

  clkdiv_rst_seq dut (
    .hclkin        (hclkin),
    .rst           (rst),
    .pll_lock      (pll_lock),
`ifdef CLKDIV_SEQ_SOFTRST_EN
    .soft_rst      (soft_rst),
`endif
    .clkdiv_resetn (clkdiv_resetn),
    .div_rst       (div_rst),
    .ready         (ready),
    .relock_cnt    (relock_cnt)
  );

  clkdiv_rst_seq #(
    .LOCK_SYNC_STAGES (2),
    .LOCK_STABLE_CYC  (1),
    .DIV_RST_HOLD     (1),
    .POST_REL_CYC     (1),
    .CNT_W            (4)
  ) dut_s (
    .hclkin        (hclkin),
    .rst           (rst),
    .pll_lock      (pll_lock_s),
`ifdef CLKDIV_SEQ_SOFTRST_EN
    .soft_rst      (soft_rst_s),
`endif
    .clkdiv_resetn (clkdiv_resetn_s),
    .div_rst       (div_rst_s),
    .ready         (ready_s),
    .relock_cnt    (relock_cnt_s)
  );

  // Call right after a negedge input change; edge 1 is the next posedge.
  task automatic measure(output int t_rel, output int t_rdy);
    t_rel = -1;
    t_rdy = -1;
    for (int n = 1; n <= 600 && t_rdy < 0; n++) begin
      @(posedge hclkin);
      @(negedge hclkin);
      if (clkdiv_resetn && t_rel < 0) t_rel = n;
      if (ready && !div_rst && t_rdy < 0) t_rdy = n;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pll_lock = 1'b0;
    repeat (5) @(negedge hclkin);
    n_checks += 4;
    if (clkdiv_resetn !== 1'b0) begin n_fail++; $display("FAIL reset_clkdiv_resetn got %b want 0", clkdiv_resetn); end
    if (div_rst !== 1'b1)       begin n_fail++; $display("FAIL reset_div_rst got %b want 1", div_rst); end
    if (ready !== 1'b0)         begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
    if (relock_cnt !== 8'd0)    begin n_fail++; $display("FAIL reset_relock_cnt got %0d want 0", relock_cnt); end
    rst = 1'b0;
    repeat (400) @(negedge hclkin);
    n_checks += 3;
    if (clkdiv_resetn !== 1'b0) begin n_fail++; $display("FAIL idle_clkdiv_resetn got %b want 0", clkdiv_resetn); end
    if (div_rst !== 1'b1)       begin n_fail++; $display("FAIL idle_div_rst got %b want 1", div_rst); end
    if (ready !== 1'b0)         begin n_fail++; $display("FAIL idle_ready got %b want 0", ready); end
  endtask

  task automatic test_sequence();
    int t_rel, t_rdy;
    pll_lock = 1'b1;
    measure(t_rel, t_rdy);
    n_checks += 2;
    if (t_rel != 275) begin n_fail++; $display("FAIL seq_t_rel got %0d want 275", t_rel); end
    if (t_rdy != 339) begin n_fail++; $display("FAIL seq_t_rdy got %0d want 339", t_rdy); end
  endtask

  task automatic test_lock_loss();
    int waited;
    pll_lock = 1'b0;
    repeat (2) begin
      @(posedge hclkin);
      @(negedge hclkin);
    end
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL loss_early_ready got %b want 1", ready); end
    @(posedge hclkin);
    @(negedge hclkin);
    n_checks += 4;
    if (clkdiv_resetn !== 1'b0) begin n_fail++; $display("FAIL loss_clkdiv_resetn got %b want 0", clkdiv_resetn); end
    if (div_rst !== 1'b1)       begin n_fail++; $display("FAIL loss_div_rst got %b want 1", div_rst); end
    if (ready !== 1'b0)         begin n_fail++; $display("FAIL loss_ready got %b want 0", ready); end
    if (relock_cnt !== 8'd1)    begin n_fail++; $display("FAIL loss_relock_cnt got %0d want 1", relock_cnt); end

    for (int i = 0; i < 300; i++) begin
      pll_lock_s = 1'b1;
      waited = 0;
      while (ready_s !== 1'b1 && waited < 40) begin
        @(negedge hclkin);
        waited++;
      end
      n_checks++;
      if (ready_s !== 1'b1) begin n_fail++; $display("FAIL sat_ready_timeout iter %0d got %b want 1", i, ready_s); end
      pll_lock_s = 1'b0;
      waited = 0;
      while (ready_s !== 1'b0 && waited < 40) begin
        @(negedge hclkin);
        waited++;
      end
      n_checks++;
      if (relock_cnt_s !== ((i + 1 > 255) ? 8'd255 : 8'(i + 1))) begin
        n_fail++;
        $display("FAIL sat_relock_cnt iter %0d got %0d want %0d", i, relock_cnt_s, (i + 1 > 255) ? 255 : i + 1);
      end
    end
  endtask

  task automatic test_glitch();
    int t_rel, t_rdy;
    pll_lock = 1'b1;
    repeat (203) begin
      @(posedge hclkin);
      @(negedge hclkin);
    end
    pll_lock = 1'b0;
    @(negedge hclkin);
    pll_lock = 1'b1;
    measure(t_rel, t_rdy);
    n_checks += 2;
    if (t_rel != 275) begin n_fail++; $display("FAIL glitch_t_rel got %0d want 275", t_rel); end
    if (t_rdy != 339) begin n_fail++; $display("FAIL glitch_t_rdy got %0d want 339", t_rdy); end
  endtask

  task automatic test_rst_settle();
    int t_rel, t_rdy;
    @(negedge hclkin);
    rst = 1'b1;
    @(negedge hclkin);
    rst = 1'b0;
    repeat (285) @(negedge hclkin);
    n_checks += 2;
    if (clkdiv_resetn !== 1'b1) begin n_fail++; $display("FAIL settle_clkdiv_resetn got %b want 1", clkdiv_resetn); end
    if (ready !== 1'b0)         begin n_fail++; $display("FAIL settle_ready got %b want 0", ready); end
    #2 rst = 1'b1;
    #1;
    n_checks += 3;
    if (clkdiv_resetn !== 1'b0) begin n_fail++; $display("FAIL async_clkdiv_resetn got %b want 0", clkdiv_resetn); end
    if (div_rst !== 1'b1)       begin n_fail++; $display("FAIL async_div_rst got %b want 1", div_rst); end
    if (ready !== 1'b0)         begin n_fail++; $display("FAIL async_ready got %b want 0", ready); end
    repeat (2) @(negedge hclkin);
    rst = 1'b0;
    measure(t_rel, t_rdy);
    n_checks += 2;
    if (t_rel != 275) begin n_fail++; $display("FAIL rst_t_rel got %0d want 275", t_rel); end
    if (t_rdy != 339) begin n_fail++; $display("FAIL rst_t_rdy got %0d want 339", t_rdy); end
  endtask

`ifdef CLKDIV_SEQ_SOFTRST_EN
  task automatic test_soft_rst();
    int t_rel, t_rdy;
    logic [7:0] relock_before;
    relock_before = relock_cnt;
    soft_rst = 1'b1;
    @(posedge hclkin);
    @(negedge hclkin);
    n_checks += 3;
    if (clkdiv_resetn !== 1'b0) begin n_fail++; $display("FAIL soft_clkdiv_resetn got %b want 0", clkdiv_resetn); end
    if (div_rst !== 1'b1)       begin n_fail++; $display("FAIL soft_div_rst got %b want 1", div_rst); end
    if (ready !== 1'b0)         begin n_fail++; $display("FAIL soft_ready got %b want 0", ready); end
    repeat (2) @(negedge hclkin);
    soft_rst = 1'b0;
    measure(t_rel, t_rdy);
    n_checks += 3;
    if (t_rel != 16) begin n_fail++; $display("FAIL soft_t_rel got %0d want 16", t_rel); end
    if (t_rdy != 80) begin n_fail++; $display("FAIL soft_t_rdy got %0d want 80", t_rdy); end
    if (relock_cnt !== relock_before) begin n_fail++; $display("FAIL soft_relock_cnt got %0d want %0d", relock_cnt, relock_before); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_lock_loss();
    test_glitch();
    test_rst_settle();
`ifdef CLKDIV_SEQ_SOFTRST_EN
    test_soft_rst();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
